// File: rtl/dyn_add_reader.sv
// Requester side of the dynamic adder interface: launches operands into an
// external ripple adder, sizes the wait from the adder's propagate vector and
// returns the captured sum on a valid/ready port.
module dyn_add_reader #(
  parameter int unsigned N               = 8,
  parameter int unsigned CHAIN_PER_CYCLE = 4,
  localparam int unsigned CW             = $clog2(N / CHAIN_PER_CYCLE + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic          in_cin,
  output logic          add_enable,
  output logic [N-1:0]  add_a,
  output logic [N-1:0]  add_b,
  output logic          add_cin,
  input  logic [N-1:0]  add_p,
  input  logic [N-1:0]  add_s,
  input  logic          add_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_sum,
  output logic          out_cout,
  output logic [CW-1:0] out_cycles
);

  localparam int unsigned LW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [LW-1:0]   run_len_c;
  logic [CW-1:0]   launch_w_c;

  // Longest run of consecutive ones: bounds how far a carry can ripple.
  function automatic logic [LW-1:0] longest_run(input logic [N-1:0] p);
    logic [LW-1:0] run;
    logic [LW-1:0] best;
    run  = '0;
    best = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (p[i]) begin
        run = run + LW'(1);
        if (run > best) best = run;
      end else begin
        run = '0;
      end
    end
    return best;
  endfunction

  // Wait length derived from the propagate vector seen during LAUNCH.
  always_comb begin
    run_len_c  = longest_run(add_p);
    launch_w_c = CW'(run_len_c / LW'(CHAIN_PER_CYCLE)) + CW'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)          state_next = LAUNCH;
      LAUNCH:                         state_next = WAIT;
      WAIT:    if (cnt == CW'(1))     state_next = HOLD;
      HOLD:    if (out_ready)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Handshake/enable outputs registered from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready   <= 1'b1;
      add_enable <= 1'b0;
    end else begin
      in_ready   <= (state_next == IDLE);
      add_enable <= (state_next == LAUNCH) || (state_next == WAIT);
    end
  end

  // Operand capture, wait counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_a      <= '0;
      add_b      <= '0;
      add_cin    <= 1'b0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_cout   <= 1'b0;
      out_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            add_a   <= in_a;
            add_b   <= in_b;
            add_cin <= in_cin;
          end
        end
        LAUNCH: begin
          cnt        <= launch_w_c;
          out_cycles <= launch_w_c;
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            out_sum   <= add_s;
            out_cout  <= add_cout;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dyn_add_reader.sv
// Directed bench for dyn_add_reader with a behavioural ripple adder attached.
module tb_dyn_add_reader;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a, in_b;
  logic          in_cin;
  logic          add_enable;
  logic [N-1:0]  add_a, add_b;
  logic          add_cin;
  logic [N-1:0]  add_p, add_s;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_sum;
  logic          out_cout;
  logic [CW-1:0] out_cycles;

  int checks = 0;
  int errors = 0;

  dyn_add_reader #(.N(N), .CHAIN_PER_CYCLE(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_enable(add_enable), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_p(add_p), .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_cycles(out_cycles)
  );

  always #5 clk = ~clk;

  // External adder model.
  always_comb begin
    add_p             = add_a ^ add_b;
    {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    int         cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction: accept, wait for result, check, handshake.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] exp_sum, input logic exp_cout, input int exp_cyc,
                         input string tag);
    int n;
    @(negedge clk);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " launch_en"}, 32'(add_enable), 32'd1);
    check({tag, " add_a"}, 32'(add_a), 32'(a));
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_cyc + 1));
    check({tag, " sum"}, 32'(out_sum), 32'(exp_sum));
    check({tag, " cout"}, 32'(out_cout), 32'(exp_cout));
    check({tag, " cycles"}, 32'(out_cycles), 32'(exp_cyc));
    check({tag, " hold_en"}, 32'(add_enable), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " valid_clr"}, 32'(out_valid), 32'd0);
    check({tag, " idle_rdy"}, 32'(in_ready), 32'd1);
    check({tag, " sum_held"}, 32'(out_sum), 32'(exp_sum));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 3};
    vecs[2] = '{8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 3};
    vecs[3] = '{8'h33, 8'h11, 1'b0, 8'h44, 1'b0, 1};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1};
    vecs[5] = '{8'h0F, 8'h00, 1'b1, 8'h10, 1'b0, 2};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1};
    vecs[7] = '{8'h7F, 8'h00, 1'b0, 8'h7F, 1'b0, 2};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst add_enable", 32'(add_enable), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_sum", 32'(out_sum), 32'd0);
    check("rst out_cycles", 32'(out_cycles), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].cyc,
              $sformatf("vec%0d", i));

    // Backpressure: result held while new operands wait on the input port.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h01; in_cin = 1'b0;
    @(posedge clk); #1;
    in_a = 8'h33; in_b = 8'h11;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp latency", 32'(n), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp out_sum", 32'(out_sum), 32'h10);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp add_a", 32'(add_a), 32'h0F);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    check("bp no bypass", 32'(add_enable), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp accept en", 32'(add_enable), 32'd1);
    check("bp accept add_a", 32'(add_a), 32'h33);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp2 sum", 32'(out_sum), 32'h44);
    check("bp2 cycles", 32'(out_cycles), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during WAIT of a long-carry transaction.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h00; in_cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rw in wait", 32'(add_enable), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rw in_ready", 32'(in_ready), 32'd1);
    check("rw add_enable", 32'(add_enable), 32'd0);
    check("rw out_valid", 32'(out_valid), 32'd0);
    check("rw out_cycles", 32'(out_cycles), 32'd0);
    run_txn(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 3, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
